// File: rtl/mul8_seq_if.sv
// Operand, result and handshake bundle for the mul8_seq shift-and-add multiplier.
// The master drives the operands and start; the slave (multiplier) returns product and status.
interface mul8_seq_if;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        busy;
    logic        done;

    modport master (output start, A, B, input P, busy, done);
    modport slave  (input start, A, B, output P, busy, done);
endinterface

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one add8_c ripple adder reused for
// 8 iterations, followed by a registered 16-bit product and a one-cycle done pulse.
module mul8_seq (
    input  logic     clk,
    input  logic     rst,
    mul8_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state;
    logic [7:0] m;
    logic [7:0] acc;
    logic [7:0] q;
    logic [2:0] cnt;

    logic [7:0] sum;
    logic       co;
    logic       c;
    logic [7:0] t;

    add8_c u_add (
        .a  (acc),
        .b  (m),
        .s  (sum),
        .co (co)
    );

    // The carry-out is the ninth bit of the partial product; it becomes ACC's new MSB.
    always_comb begin
        // NOTE: every always_comb output is given a value on every path, so no latch is inferred.
        {c, t} = q[0] ? {co, sum} : {1'b0, acc};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state    <= IDLE;
            m        <= '0;
            acc      <= '0;
            q        <= '0;
            cnt      <= '0;
            bus.P    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        m        <= bus.A;
                        q        <= bus.B;
                        acc      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc <= {c, t[7:1]};
                    q   <= {t[0], q[7:1]};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bus.P    <= {c, t[7:1], t[0], q[7:1]};
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// Team 8-bit ripple adder: {co, s} = a + b, built from a chain of full-adder cells.
module add8_c (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s,
    output logic       co
);
    logic [8:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[8];
endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: cycle model from the operation/timing rules plus
// directed vectors with hand-computed products.
module tb_mul8_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul8_seq_if bus ();

    mul8_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: an accepted start schedules A*B to appear 8 busy cycles later, then one done cycle.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_p    = '0;
    logic [15:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_p    = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_p    = m_pend;
            end
        end else if (bus.start) begin
            m_pend = 16'(bus.A) * 16'(bus.B);
            m_left = 8;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
            check("model_done", {31'd0, bus.done}, {31'd0, m_done});
            check("model_p", {16'd0, bus.P}, {16'd0, m_p});
        end
    end

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        bus.A = a; bus.B = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output logic [15:0] p, output int nbusy);
        logic found;
        found = 1'b0;
        nbusy = 0;
        p     = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                p = bus.P;
                found = 1'b1;
                break;
            end
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic quiet_cycles(input string name, input int n);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) act++;
        end
        check(name, act, 0);
    endtask

    logic [15:0] p, p0, p1;
    int          nb, t0, t1;
    logic [7:0]  ra, rb;

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
        @(posedge clk);
        @(negedge clk);
        check("reset_p", {16'd0, bus.P}, 32'h0);
        check("reset_busy", {31'd0, bus.busy}, 32'h0);
        check("reset_done", {31'd0, bus.done}, 32'h0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        start_op(8'hFF, 8'hFF);
        wait_done(p, nb);
        check("ffxff_busy_cycles", nb, 8);
        check("ffxff_p", {16'd0, p}, 32'hFE01);
        @(negedge clk);
        check("ffxff_done_pulse", {31'd0, bus.done}, 32'h0);
        quiet_cycles("ffxff_idle", 3);
        check("ffxff_hold", {16'd0, bus.P}, 32'hFE01);

        start_op(8'd13, 8'd11);
        wait_done(p, nb);
        check("13x11_p", {16'd0, p}, 32'h008F);

        start_op(8'h00, 8'hA5);
        wait_done(p, nb);
        check("0xa5_p", {16'd0, p}, 32'h0000);

        start_op(8'h80, 8'h02);
        wait_done(p, nb);
        check("80x02_p", {16'd0, p}, 32'h0100);

        // Operand change and start pulse during CALC cycle 4 must be ignored.
        start_op(8'h03, 8'h05);
        repeat (3) @(posedge clk);
        #1 bus.A = 8'hFF; bus.B = 8'hFF; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(p, nb);
        check("ignore_start_p", {16'd0, p}, 32'h000F);
        quiet_cycles("ignore_start_no_second", 12);

        // Start held high: back-to-back operations every 10 cycles.
        @(posedge clk); #1;
        bus.A = 8'd2; bus.B = 8'd3; bus.start = 1'b1;
        t0 = -1; t1 = -1; p0 = '0; p1 = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (t0 < 0) begin
                    t0 = i; p0 = bus.P; bus.A = 8'd4; bus.B = 8'd5;
                end else begin
                    t1 = i; p1 = bus.P;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check("held_p0", {16'd0, p0}, 32'h0006);
        check("held_p1", {16'd0, p1}, 32'h0014);
        check("held_period", t1 - t0, 10);
        quiet_cycles("held_drain", 12);

        // Reset mid-CALC aborts and clears P.
        start_op(8'd7, 8'd9);
        wait_done(p, nb);
        check("7x9_p", {16'd0, p}, 32'h003F);
        start_op(8'hFF, 8'hFF);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'h0);
        check("abort_p", {16'd0, bus.P}, 32'h0000);
        check("abort_done", {31'd0, bus.done}, 32'h0);
        quiet_cycles("abort_no_done", 12);
        start_op(8'd2, 8'd2);
        wait_done(p, nb);
        check("2x2_p", {16'd0, p}, 32'h0004);

        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            start_op(ra, rb);
            wait_done(p, nb);
            check("rand_p", {16'd0, p}, {16'd0, 16'(ra) * 16'(rb)});
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
